// File: rtl/ifmap_spad_ctrl.sv
// Sequencer for the PE ifmap scratchpad: ring-buffer fill from the input channel, then
// replays each sliding window to the MAC cfg_reuse times before refilling the freed entries.
module ifmap_spad_ctrl #(
  parameter int unsigned DEPTH  = 12,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_taps,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [CNT_W-1:0]  cfg_reuse,
  input  logic [CNT_W-1:0]  cfg_num_win,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic              rd_last,
  output logic [ADDR_W-1:0] spad_addr,
  output logic              spad_we,
  output logic [DATA_W-1:0] spad_din,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {StIdle, StFill, StRead, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);

  state_e            state_q;
  logic [ADDR_W-1:0] taps_q, stride_q;
  logic [CNT_W-1:0]  reuse_q, num_win_q;
  logic [ADDR_W-1:0] wr_ptr_q, base_q, need_q, tap_q;
  logic [CNT_W-1:0]  pass_q, win_q;
  logic              cfg_err_q;

  logic              cfg_ok;
  logic              last_tap;
  logic [ADDR_W-1:0] rd_addr;

  // Both operands are below DEPTH (stride may equal DEPTH), so one subtract suffices.
  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DepthW) s = s - DepthW;
    return s[ADDR_W-1:0];
  endfunction

  assign cfg_ok = (cfg_taps != '0) && ({1'b0, cfg_taps} <= DepthW) &&
                  (cfg_stride != '0) && (cfg_stride <= cfg_taps) &&
                  (cfg_reuse != '0) && (cfg_num_win != '0);

  assign last_tap = (tap_q == taps_q - ADDR_W'(1));
  assign rd_addr  = wrap_add(base_q, tap_q);

  // Combinational so the spad sees a stable address half a cycle before its falling edge.
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign cfg_err   = cfg_err_q;
  assign in_ready  = (state_q == StFill);
  assign spad_we   = in_ready & in_valid;
  assign spad_din  = spad_we ? in_data : '0;
  assign rd_valid  = (state_q == StRead);
  assign rd_last   = rd_valid & last_tap;
  assign spad_addr = in_ready ? wr_ptr_q : (rd_valid ? rd_addr : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      taps_q    <= '0;
      stride_q  <= '0;
      reuse_q   <= '0;
      num_win_q <= '0;
      wr_ptr_q  <= '0;
      base_q    <= '0;
      need_q    <= '0;
      tap_q     <= '0;
      pass_q    <= '0;
      win_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_ok) begin
              taps_q    <= cfg_taps;
              stride_q  <= cfg_stride;
              reuse_q   <= cfg_reuse;
              num_win_q <= cfg_num_win;
              wr_ptr_q  <= '0;
              base_q    <= '0;
              need_q    <= cfg_taps;
              tap_q     <= '0;
              pass_q    <= '0;
              win_q     <= '0;
              state_q   <= StFill;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        StFill: begin
          if (in_valid) begin
            wr_ptr_q <= (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + ADDR_W'(1);
            need_q   <= need_q - ADDR_W'(1);
            if (need_q == ADDR_W'(1)) begin
              tap_q   <= '0;
              pass_q  <= '0;
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          if (rd_ready) begin
            if (!last_tap) begin
              tap_q <= tap_q + ADDR_W'(1);
            end else begin
              tap_q <= '0;
              if (pass_q != reuse_q - CNT_W'(1)) begin
                pass_q <= pass_q + CNT_W'(1);
              end else if (win_q == num_win_q - CNT_W'(1)) begin
                state_q <= StDone;
              end else begin
                // Slide the window; only the stride oldest entries need replacing.
                pass_q  <= '0;
                win_q   <= win_q + CNT_W'(1);
                base_q  <= wrap_add(base_q, stride_q);
                need_q  <= stride_q;
                state_q <= StFill;
              end
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
